dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-ported, byte-addressable data memory between the two issue lanes of the superscalar core. Lane A is the older instruction; lane B is the younger.
- Serialises same-cycle requests in program order and checks each access for alignment, range and legal mode.
- Returns load data one cycle after the access, with the lane's sign or zero extension applied.
- Sits between the execute/memory stage and data_memory, driving its mem_mode, address, write data and write enable.

Parameters:
- DEPTH, 1024, data memory size in bytes; valid accesses satisfy addr + size <= DEPTH.
- CHECK_ALIGN, 1, when 1 a misaligned halfword or word access faults; when 0 alignment is not checked.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- a_valid / b_valid  in  1  lane request valid
- a_ready / b_ready  out  1  lane may issue this cycle
- a_we / b_we  in  1  1 = store, 0 = load
- a_mode / b_mode  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- a_unsigned / b_unsigned  in  1  zero-extend load data (LBU/LHU)
- a_addr / b_addr  in  32  byte address
- a_wdata / b_wdata  in  32  store data
- a_rvalid / b_rvalid  out  1  response pulse, one per accepted request
- a_rdata / b_rdata  out  32  extended load data; 0 for stores and faults
- a_fault / b_fault  out  1  qualifies rvalid: access suppressed
- mem_we  out  1  memory write enable
- mem_mode  out  2  memory access size
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  asynchronous read data from memory, sign-extended by the memory
- busy  out  1  high in B_PEND state

Behaviour:
- States: IDLE and B_PEND.
- Handshake: a request transfers when valid && ready. Both a_ready and b_ready equal (state == IDLE).
- IDLE, A only: A's access is presented combinationally on the mem_* outputs this cycle.
- IDLE, B only: B's access is presented on the mem_* outputs this cycle.
- IDLE, both valid: A is served this cycle. B's we, mode, unsigned, addr and wdata are latched into pending registers, and the next state is B_PEND.
- B_PEND: the pending B access is served. Both ready outputs are 0. Next state is IDLE.
- Ordering: serialisation guarantees that a lane A store is visible to a same-bundle lane B load of an overlapping address, because A's write commits at the edge before B's read.
- Fault conditions (evaluated on the served access):
  - mode == 11;
  - addr + size > DEPTH, where size is 1, 2 or 4;
  - CHECK_ALIGN and ((halfword and addr[0]) or (word and addr[1:0] != 0)).
- On a fault, mem_we is 0 for that cycle.
- mem_we = served && we && !fault. When no access is served, all mem_* outputs are 0.
- Response: one cycle after the served cycle, the served lane's rvalid pulses for exactly one cycle.
  - fault is set if the access faulted.
  - Load rdata is mem_rdata, registered. When unsigned, it is masked to [7:0] for byte or [15:0] for halfword. Otherwise the value is passed unchanged; the memory has already sign-extended it.
  - Store rdata is 0.
- Latency: a single request gets its response 1 cycle after acceptance. With a dual request, A responds at +1 and B at +2.
- Reset: asserting rst in any state, including B_PEND, drops the pending B and forces state IDLE.
  - Reset values: all rvalid, rdata and fault outputs 0; busy 0; pending registers 0.
  - During reset, both ready outputs and mem_we are 0.
- Reset mid-operation produces no response for the dropped request. Upstream flushes on reset.

Decomposition:
- Shared package dmem_pkg: mem_mode_e (BYTE, HALF, WORD, ILLEGAL), arb_state_e (IDLE, B_PEND), a mem_req_t struct (we, mode, uns, addr, wdata), and a size-from-mode function.
- One sub-module, dmem_access_check: combinational fault detection and load extension. It is instantiated once, on the muxed served request.

Test Plan:
- Single load: A loads a word at 0x10 holding 0xDEADBEEF → a_rvalid at +1 with a_rdata 0xDEADBEEF and a_fault 0; b_rvalid stays 0.
- Dual request: A stores word 0x12345678 to 0x20 while B loads the unsigned byte at 0x21 in the same cycle → A acked at +1. B responds at +2 with b_rdata 0x00000056. busy is high for one cycle, and both ready outputs are 0 in that cycle.
- Extension: the byte at 0x30 holds 0x80. A signed byte load returns 0xFFFFFF80; an unsigned byte load returns 0x00000080.
- Faults: a word store at 0x22 returns a_fault 1 with mem_we never asserted. A mode-11 request faults. A word at address 1022 faults because 1022+4 > 1024. Memory contents are unchanged in all three cases.
- Reset in B_PEND: a dual request, then rst asserted the next cycle → b_rvalid never pulses, state is IDLE and all outputs are 0. After release, a new A request completes normally.
- Back-to-back: A-only requests on 4 consecutive cycles → 4 responses on consecutive cycles, with ready held at 1 throughout.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: access modes, FSM states,
// the request bundle and the access-size helper.
package dmem_pkg;

  typedef enum logic [1:0] {
    BYTE    = 2'b00,
    HALF    = 2'b01,
    WORD    = 2'b10,
    ILLEGAL = 2'b11
  } mem_mode_e;

  typedef enum logic {
    IDLE   = 1'b0,
    B_PEND = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic        we;
    mem_mode_e   mode;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  // Illegal mode reports 4 so range math stays defined; it faults anyway.
  function automatic logic [2:0] size_of(mem_mode_e m);
    logic [2:0] s;
    case (m)
      BYTE:    s = 3'd1;
      HALF:    s = 3'd2;
      default: s = 3'd4;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dmem_access_check.sv
// Fault detection and load-data extension for the served access.
// Purely combinational; instantiated once on the muxed request.
module dmem_access_check
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  mem_req_t    req_i,
  input  logic [31:0] rdata_i,
  output logic        fault_o,
  output logic [31:0] rdata_o
);

  logic [32:0] end_addr;
  logic        bad_mode;
  logic        bad_range;
  logic        misalign;

  // 33-bit sum so addresses near 2^32 cannot wrap past the limit.
  assign end_addr  = {1'b0, req_i.addr} + {30'd0, size_of(req_i.mode)};
  assign bad_mode  = (req_i.mode == ILLEGAL);
  assign bad_range = (end_addr > 33'(DEPTH));
  assign misalign  = ((req_i.mode == HALF) && req_i.addr[0])
                   || ((req_i.mode == WORD) && (req_i.addr[1:0] != 2'b00));

  assign fault_o = bad_mode || bad_range || (CHECK_ALIGN && misalign);

  // Memory already sign-extends; only the unsigned forms need masking.
  always_comb begin
    rdata_o = rdata_i;
    if (req_i.uns) begin
      case (req_i.mode)
        BYTE:    rdata_o = {24'd0, rdata_i[7:0]};
        HALF:    rdata_o = {16'd0, rdata_i[15:0]};
        default: rdata_o = rdata_i;
      endcase
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-lane arbiter for the single-ported data memory. Same-cycle
// requests are serialised A then B; responses return one cycle later.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic        a_we,
  input  logic [1:0]  a_mode,
  input  logic        a_unsigned,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_rvalid,
  output logic [31:0] a_rdata,
  output logic        a_fault,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic        b_we,
  input  logic [1:0]  b_mode,
  input  logic        b_unsigned,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_rvalid,
  output logic [31:0] b_rdata,
  output logic        b_fault,
  output logic        mem_we,
  output logic [1:0]  mem_mode,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  arb_state_e  state_q, state_d;
  mem_req_t    pend_q, pend_d;
  logic        a_rvalid_q, a_rvalid_d;
  logic        b_rvalid_q, b_rvalid_d;
  logic        a_fault_q, a_fault_d;
  logic        b_fault_q, b_fault_d;
  logic [31:0] a_rdata_q, a_rdata_d;
  logic [31:0] b_rdata_q, b_rdata_d;

  mem_req_t    a_req, b_req, srv_req;
  logic        idle;
  logic        serve_a, serve_b, serve_p, served;
  logic        srv_fault;
  logic [31:0] srv_ext;
  logic [31:0] resp_data;

  assign a_req = '{we: a_we, mode: mem_mode_e'(a_mode), uns: a_unsigned,
                   addr: a_addr, wdata: a_wdata};
  assign b_req = '{we: b_we, mode: mem_mode_e'(b_mode), uns: b_unsigned,
                   addr: b_addr, wdata: b_wdata};

  assign idle    = (state_q == IDLE);
  assign a_ready = !rst && idle;
  assign b_ready = !rst && idle;
  assign busy    = (state_q == B_PEND);

  assign serve_a = !rst && idle && a_valid;
  assign serve_b = !rst && idle && !a_valid && b_valid;
  assign serve_p = !rst && !idle;
  assign served  = serve_a || serve_b || serve_p;

  always_comb begin
    srv_req = '0;
    unique case (1'b1)
      serve_a: srv_req = a_req;
      serve_b: srv_req = b_req;
      serve_p: srv_req = pend_q;
      default: srv_req = '0;
    endcase
  end

  dmem_access_check #(
    .DEPTH       (DEPTH),
    .CHECK_ALIGN (CHECK_ALIGN)
  ) u_check (
    .req_i   (srv_req),
    .rdata_i (mem_rdata),
    .fault_o (srv_fault),
    .rdata_o (srv_ext)
  );

  assign mem_we    = served && srv_req.we && !srv_fault;
  assign mem_mode  = srv_req.mode;
  assign mem_addr  = srv_req.addr;
  assign mem_wdata = srv_req.wdata;

  assign resp_data = (served && !srv_req.we && !srv_fault) ? srv_ext : 32'd0;

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    a_rvalid_d = serve_a;
    a_fault_d  = serve_a && srv_fault;
    a_rdata_d  = serve_a ? resp_data : 32'd0;
    b_rvalid_d = serve_b || serve_p;
    b_fault_d  = (serve_b || serve_p) && srv_fault;
    b_rdata_d  = (serve_b || serve_p) ? resp_data : 32'd0;
    if (serve_a && b_valid) begin
      state_d = B_PEND;
      pend_d  = b_req;
    end else if (serve_p) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_fault_q  <= 1'b0;
      b_fault_q  <= 1'b0;
      a_rdata_q  <= 32'd0;
      b_rdata_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_fault_q  <= a_fault_d;
      b_fault_q  <= b_fault_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_fault  = a_fault_q;
  assign b_fault  = b_fault_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-array memory plus an in-order
// reference executor fed by directed and random two-lane traffic.
module tb_dmem_arbiter;

  typedef struct packed {
    bit        v;
    bit        lane;
    bit        we;
    bit [1:0]  mode;
    bit        uns;
    bit [31:0] addr;
    bit [31:0] wdata;
  } tb_req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 0, a_we = 0, a_unsigned = 0;
  logic [1:0]  a_mode = 0;
  logic [31:0] a_addr = 0, a_wdata = 0;
  logic        b_valid = 0, b_we = 0, b_unsigned = 0;
  logic [1:0]  b_mode = 0;
  logic [31:0] b_addr = 0, b_wdata = 0;
  logic        a_ready, b_ready, a_rvalid, b_rvalid, a_fault, b_fault;
  logic [31:0] a_rdata, b_rdata;
  logic        mem_we, busy;
  logic [1:0]  mem_mode;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we),
    .a_mode(a_mode), .a_unsigned(a_unsigned), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .a_fault(a_fault),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we),
    .b_mode(b_mode), .b_unsigned(b_unsigned), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .b_fault(b_fault),
    .mem_we(mem_we), .mem_mode(mem_mode), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic bit [7:0] seed(int i);
    case (i)
      16: return 8'hEF;
      17: return 8'hBE;
      18: return 8'hAD;
      19: return 8'hDE;
      48: return 8'h80;
      default: return 8'((i * 37 + 11) & 255);
    endcase
  endfunction

  // Behavioural data_memory: async sign-extending read, clocked write.
  logic [7:0] dmem [0:1023];
  logic       mem_init = 1'b1;
  logic [9:0] m0, m1, m2, m3;
  assign m0 = mem_addr[9:0];
  assign m1 = m0 + 10'd1;
  assign m2 = m0 + 10'd2;
  assign m3 = m0 + 10'd3;

  always_comb begin
    mem_rdata = 32'd0;
    case (mem_mode)
      2'd0: mem_rdata = {{24{dmem[m0][7]}}, dmem[m0]};
      2'd1: mem_rdata = {{16{dmem[m1][7]}}, dmem[m1], dmem[m0]};
      2'd2: mem_rdata = {dmem[m3], dmem[m2], dmem[m1], dmem[m0]};
      default: mem_rdata = 32'd0;
    endcase
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) dmem[i] <= seed(i);
    end else if (mem_we) begin
      dmem[m0] <= mem_wdata[7:0];
      if (mem_mode != 2'd0) dmem[m1] <= mem_wdata[15:8];
      if (mem_mode == 2'd2) begin
        dmem[m2] <= mem_wdata[23:16];
        dmem[m3] <= mem_wdata[31:24];
      end
    end
  end

  // Reference: accepted requests execute one per cycle in program order.
  bit [7:0]  rmem [1024];
  tb_req_t   q [$];
  bit        e_av, e_af, e_bv, e_bf;
  bit [31:0] e_ad, e_bd;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic tb_req_t mk(bit v, bit we, bit [1:0] mode, bit uns,
                                 bit [31:0] addr, bit [31:0] wdata);
    tb_req_t r;
    r = '{v: v, lane: 1'b0, we: we, mode: mode, uns: uns,
          addr: addr, wdata: wdata};
    return r;
  endfunction

  function automatic bit ref_fault(tb_req_t r);
    longint sz;
    sz = (r.mode == 2'd0) ? 1 : (r.mode == 2'd1) ? 2 : 4;
    if (r.mode == 2'd3) return 1'b1;
    if (longint'({32'd0, r.addr}) + sz > 1024) return 1'b1;
    if (r.mode == 2'd1 && r.addr[0]) return 1'b1;
    if (r.mode == 2'd2 && r.addr[1:0] != 2'd0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic ref_exec(input tb_req_t r, output bit f,
                          output bit [31:0] d, output bit w);
    int a;
    int n;
    f = ref_fault(r);
    d = 0;
    w = 0;
    if (f) return;
    a = int'(r.addr);
    n = (r.mode == 2'd0) ? 1 : (r.mode == 2'd1) ? 2 : 4;
    if (r.we) begin
      w = 1;
      for (int k = 0; k < n; k++) rmem[a + k] = 8'(r.wdata >> (8 * k));
    end else begin
      for (int k = 0; k < n; k++) d = d | (32'(rmem[a + k]) << (8 * k));
      if (!r.uns && n == 1 && d[7])  d = d | 32'hFFFF_FF00;
      if (!r.uns && n == 2 && d[15]) d = d | 32'hFFFF_0000;
    end
  endtask

  task automatic chk_resp();
    chk("a_rvalid", a_rvalid, e_av);
    chk("a_fault",  a_fault,  e_af);
    chk("a_rdata",  a_rdata,  e_ad);
    chk("b_rvalid", b_rvalid, e_bv);
    chk("b_fault",  b_fault,  e_bf);
    chk("b_rdata",  b_rdata,  e_bd);
  endtask

  task automatic step(input tb_req_t ra_in, input tb_req_t rb_in);
    tb_req_t   ra, rb, s;
    bit        f, w, rdy;
    bit [31:0] d;
    ra = ra_in; ra.lane = 1'b0;
    rb = rb_in; rb.lane = 1'b1;
    @(negedge clk);
    chk_resp();
    a_valid = ra.v; a_we = ra.we; a_mode = ra.mode;
    a_unsigned = ra.uns; a_addr = ra.addr; a_wdata = ra.wdata;
    b_valid = rb.v; b_we = rb.we; b_mode = rb.mode;
    b_unsigned = rb.uns; b_addr = rb.addr; b_wdata = rb.wdata;
    #1;
    rdy = (q.size() == 0);
    chk("a_ready", a_ready, rdy);
    chk("b_ready", b_ready, rdy);
    chk("busy", busy, !rdy);
    if (rdy) begin
      if (ra.v) q.push_back(ra);
      if (rb.v) q.push_back(rb);
    end
    {e_av, e_af, e_ad, e_bv, e_bf, e_bd} = '0;
    w = 0;
    if (q.size() != 0) begin
      s = q.pop_front();
      ref_exec(s, f, d, w);
      if (s.lane == 1'b0) {e_av, e_af, e_ad} = {1'b1, f, d};
      else                {e_bv, e_bf, e_bd} = {1'b1, f, d};
    end
    chk("mem_we", mem_we, w);
  endtask

  function automatic tb_req_t rnd_req();
    int      sel;
    bit [31:0] ad;
    sel = $urandom_range(0, 9);
    if (sel < 8)       ad = 32'($urandom_range(0, 127));
    else if (sel == 8) ad = 32'(1016 + $urandom_range(0, 7));
    else               ad = $urandom;
    return mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              ad, $urandom);
  endfunction

  tb_req_t nop;
  int      nm;

  initial begin
    nop = '0;
    for (int i = 0; i < 1024; i++) rmem[i] = seed(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk_resp();
    rst = 1'b0;
    mem_init = 1'b0;

    // single word load
    step(mk(1, 0, 2'd2, 0, 32'h10, 0), nop);
    step(nop, nop);
    chk("single_rdata", a_rdata, 32'hDEADBEEF);
    chk("single_b_rvalid", b_rvalid, 0);

    // dual: A store then B byte load of the same word
    step(mk(1, 1, 2'd2, 0, 32'h20, 32'h12345678),
         mk(1, 0, 2'd0, 1, 32'h21, 0));
    step(nop, nop);
    chk("dual_busy", busy, 1);
    chk("dual_a_rvalid", a_rvalid, 1);
    step(nop, nop);
    chk("dual_b_rdata", b_rdata, 32'h00000056);

    // sign / zero extension
    step(mk(1, 0, 2'd0, 0, 32'h30, 0), nop);
    step(mk(1, 0, 2'd0, 1, 32'h30, 0), nop);
    chk("ext_signed", a_rdata, 32'hFFFFFF80);
    step(nop, nop);
    chk("ext_unsigned", a_rdata, 32'h00000080);

    // faults: misaligned store, illegal mode, out of range
    step(mk(1, 1, 2'd2, 0, 32'h22, 32'hCAFEF00D), nop);
    step(mk(1, 1, 2'd3, 0, 32'h40, 32'h11111111), nop);
    chk("fault_align", a_fault, 1);
    step(mk(1, 0, 2'd2, 0, 32'd1022, 0), nop);
    chk("fault_mode", a_fault, 1);
    step(nop, nop);
    chk("fault_range", a_fault, 1);

    // reset while B is pending
    step(mk(1, 0, 2'd2, 0, 32'h40, 0), mk(1, 0, 2'd1, 0, 32'h42, 0));
    @(negedge clk);
    rst = 1'b1;
    a_valid = 0; b_valid = 0;
    #1;
    chk("rstp_busy", busy, 0);
    chk("rstp_a_ready", a_ready, 0);
    chk("rstp_b_ready", b_ready, 0);
    chk("rstp_mem_we", mem_we, 0);
    q.delete();
    {e_av, e_af, e_ad, e_bv, e_bf, e_bd} = '0;
    chk_resp();
    @(negedge clk);
    chk("rstp_b_rvalid", b_rvalid, 0);
    rst = 1'b0;
    step(mk(1, 0, 2'd2, 0, 32'h10, 0), nop);
    step(nop, nop);
    chk("rstp_after", a_rdata, 32'hDEADBEEF);

    // back-to-back A-only requests
    for (int i = 0; i < 4; i++)
      step(mk(1, 0, 2'd2, 0, 32'(4 * i), 0), nop);
    step(nop, nop);

    // random two-lane traffic
    for (int i = 0; i < 400; i++) step(rnd_req(), rnd_req());
    step(nop, nop);
    step(nop, nop);
    step(nop, nop);

    nm = 0;
    for (int i = 0; i < 1024; i++)
      if (dmem[i] !== rmem[i]) nm++;
    chk("mem_image", nm, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
